// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port external SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned ADDR_W_DEF = 19;
  localparam int unsigned DATA_W_DEF = 8;

  // Wide enough for the largest legal WAIT_CYCLES-1 (14).
  localparam int unsigned CNT_W = 4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signal bundle for sram_arbiter; slave = arbiter view, master = bench view.
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              iReq0;
  logic              iReq1;
  logic              iWe0;
  logic              iWe1;
  logic [ADDR_W-1:0] iAddr0;
  logic [ADDR_W-1:0] iAddr1;
  logic [DATA_W-1:0] iWData0;
  logic [DATA_W-1:0] iWData1;
  logic              oAck0;
  logic              oAck1;
  logic [DATA_W-1:0] oRData;
  logic [DATA_W-1:0] iSramData;
  logic [ADDR_W-1:0] oSramAddr;
  logic [DATA_W-1:0] oSramData;
  logic              oSramCe;
  logic              oSramWe;
  logic              oSramOe;

  modport slave (
    input  iReq0, iReq1, iWe0, iWe1, iAddr0, iAddr1, iWData0, iWData1, iSramData,
    output oAck0, oAck1, oRData, oSramAddr, oSramData, oSramCe, oSramWe, oSramOe
  );

  modport master (
    output iReq0, iReq1, iWe0, iWe1, iAddr0, iAddr1, iWData0, iWData1, iSramData,
    input  oAck0, oAck1, oRData, oSramAddr, oSramData, oSramCe, oSramWe, oSramOe
  );

endinterface

// File: rtl/sram_arb_grant.sv
// Winner select and priority pointer for sram_arbiter.
// SRAM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 0 has fixed priority.
module sram_arb_grant
  import sram_arb_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_grant,
  input  logic i_done,
  output logic o_any,
  output logic o_winner,
  output logic o_owner
);

  logic r_prio;
  logic r_owner;
  logic w_winner;

  assign o_any    = i_req0 | i_req1;
  assign o_winner = w_winner;
  assign o_owner  = r_owner;

  always_comb begin
    w_winner = PORT0;
    if (i_req0 && i_req1) begin
      w_winner = r_prio;
    end else if (i_req1) begin
      w_winner = PORT1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_prio  <= PORT0;
      r_owner <= PORT0;
    end else begin
      if (i_grant) begin
        r_owner <= w_winner;
      end
      if (i_done) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        // Priority passes to the port that was not just served.
        r_prio <= ~r_owner;
`else
        r_prio <= PORT0;
`endif
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and IDLE/SETUP/ACCESS/DONE strobe sequencer for an async SRAM.
// Arbitration policy chosen by SRAM_ARB_ROUND_ROBIN_EN (see sram_arb_grant).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF
) (
  input  logic           Clock,
  input  logic           Reset,
  sram_arbiter_if.slave  bus
);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ce_n;
  logic              r_we_n;
  logic              r_oe_n;
  logic              r_ack0;
  logic              r_ack1;

  logic w_any;
  logic w_winner;
  logic w_owner;
  logic w_grant;
  logic w_done;

  assign w_grant = (r_state == StIdle) && w_any;
  assign w_done  = (r_state == StDone);

  sram_arb_grant u_grant (
    .Clock    (Clock),
    .Reset    (Reset),
    .i_req0   (bus.iReq0),
    .i_req1   (bus.iReq1),
    .i_grant  (w_grant),
    .i_done   (w_done),
    .o_any    (w_any),
    .o_winner (w_winner),
    .o_owner  (w_owner)
  );

  assign bus.oSramAddr = r_addr;
  assign bus.oSramData = r_wdata;
  assign bus.oRData    = r_rdata;
  assign bus.oSramCe   = r_ce_n;
  assign bus.oSramWe   = r_we_n;
  assign bus.oSramOe   = r_oe_n;
  assign bus.oAck0     = r_ack0;
  assign bus.oAck1     = r_ack1;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ce_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Address/data land on the pins together with CE; WE/OE follow a cycle later.
          if (w_any) begin
            r_state <= StSetup;
            r_ce_n  <= 1'b0;
            if (w_winner == PORT1) begin
              r_we    <= bus.iWe1;
              r_addr  <= bus.iAddr1;
              r_wdata <= bus.iWData1;
            end else begin
              r_we    <= bus.iWe0;
              r_addr  <= bus.iAddr0;
              r_wdata <= bus.iWData0;
            end
          end
        end
        StSetup: begin
          r_state <= StAccess;
          r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
          r_we_n  <= ~r_we;
          r_oe_n  <= r_we;
        end
        StAccess: begin
          if (r_cnt == '0) begin
            r_state <= StDone;
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ack0  <= (w_owner == PORT0);
            r_ack1  <= (w_owner == PORT1);
            if (!r_we) begin
              r_rdata <= bus.iSramData;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed, table-driven bench for sram_arbiter (WAIT_CYCLES 2, plus 1 and 15 latency builds).
module tb_sram_arbiter;
  import sram_arb_pkg::*;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam int W = 2;

  typedef struct {
    logic        port;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  sram;
    logic [7:0]  exp_rd;
  } vec_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 Clock = ~Clock;

  sram_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus ();
  sram_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus1 ();
  sram_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus15 ();

  sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(19), .DATA_W(8)) dut (
    .Clock (Clock), .Reset (Reset), .bus (bus)
  );
  sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(19), .DATA_W(8)) dut_w1 (
    .Clock (Clock), .Reset (Reset), .bus (bus1)
  );
  sram_arbiter #(.WAIT_CYCLES(15), .ADDR_W(19), .DATA_W(8)) dut_w15 (
    .Clock (Clock), .Reset (Reset), .bus (bus15)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; runs one transaction and checks it.
  task automatic run_vec(input vec_t v, input string tag);
    int lat = 0, we_lo = 0, oe_lo = 0, viol = 0, addr_bad = 0, oth = 0;
    logic [7:0] sd = '0, rd = '0;
    logic own;
    bus.iSramData = v.sram;
    if (v.port == PORT0) begin
      bus.iReq0 = 1'b1; bus.iWe0 = v.we; bus.iAddr0 = v.addr; bus.iWData0 = v.wdata;
    end else begin
      bus.iReq1 = 1'b1; bus.iWe1 = v.we; bus.iAddr1 = v.addr; bus.iWData1 = v.wdata;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (!bus.oSramWe) we_lo++;
      if (!bus.oSramOe) oe_lo++;
      if ((!bus.oSramWe || !bus.oSramOe) && (bus.oSramCe || k == 1)) viol++;
      if (k == 1 && bus.oSramCe !== 1'b0) viol++;
      if (bus.oSramAddr !== v.addr) addr_bad++;
      own = (v.port == PORT0) ? bus.oAck0 : bus.oAck1;
      if ((v.port == PORT0) ? bus.oAck1 : bus.oAck0) oth++;
      if (own) begin
        lat = k; sd = bus.oSramData; rd = bus.oRData;
        break;
      end
    end
    bus.iReq0 = 1'b0;
    bus.iReq1 = 1'b0;
    check({tag, " ack latency"}, lat, W + 2);
    check({tag, " wrong-port ack"}, oth, 0);
    check({tag, " we low cycles"}, we_lo, v.we ? W : 0);
    check({tag, " oe low cycles"}, oe_lo, v.we ? 0 : W);
    check({tag, " strobe order"}, viol, 0);
    check({tag, " addr stable"}, addr_bad, 0);
    if (v.we) check({tag, " sram wdata"}, sd, v.wdata);
    check({tag, " rdata at ack"}, rd, v.exp_rd);
    @(negedge Clock);
    check({tag, " ack one cycle"}, {bus.oAck0, bus.oAck1}, 2'b00);
    check({tag, " rdata held"}, bus.oRData, v.exp_rd);
    check({tag, " strobes idle"}, {bus.oSramCe, bus.oSramWe, bus.oSramOe}, 3'b111);
  endtask

  vec_t vecs [6];

  initial begin
    int k1 = 0, k15 = 0, we1 = 0, oe15 = 0, v1 = 0, v15 = 0;
    logic [7:0] rd15 = '0;
    int t_ack [2];
    logic order [4];
    int n_gr, t_last, abort_acks;
    vec_t pv;

    vecs[0] = '{port: 1'b0, we: 1'b1, addr: 19'h00010, wdata: 8'hA5, sram: 8'hEE, exp_rd: 8'h00};
    vecs[1] = '{port: 1'b1, we: 1'b0, addr: 19'h7FFFF, wdata: 8'h00, sram: 8'h3C, exp_rd: 8'h3C};
    vecs[2] = '{port: 1'b0, we: 1'b0, addr: 19'h12345, wdata: 8'h99, sram: 8'h5A, exp_rd: 8'h5A};
    vecs[3] = '{port: 1'b1, we: 1'b1, addr: 19'h00000, wdata: 8'hFF, sram: 8'h11, exp_rd: 8'h5A};
    vecs[4] = '{port: 1'b1, we: 1'b0, addr: 19'h40001, wdata: 8'h22, sram: 8'h81, exp_rd: 8'h81};
    vecs[5] = '{port: 1'b0, we: 1'b1, addr: 19'h7FFFF, wdata: 8'h00, sram: 8'hC7, exp_rd: 8'h81};

    {bus.iReq0, bus.iReq1, bus.iWe0, bus.iWe1} = '0;
    {bus.iAddr0, bus.iAddr1, bus.iWData0, bus.iWData1, bus.iSramData} = '0;
    {bus1.iReq0, bus1.iReq1, bus1.iWe0, bus1.iWe1} = '0;
    {bus1.iAddr0, bus1.iAddr1, bus1.iWData0, bus1.iWData1, bus1.iSramData} = '0;
    {bus15.iReq0, bus15.iReq1, bus15.iWe0, bus15.iWe1} = '0;
    {bus15.iAddr0, bus15.iAddr1, bus15.iWData0, bus15.iWData1, bus15.iSramData} = '0;

    repeat (3) @(negedge Clock);
    check("reset strobes", {bus.oSramCe, bus.oSramWe, bus.oSramOe}, 3'b111);
    check("reset acks", {bus.oAck0, bus.oAck1}, 2'b00);
    check("reset addr", bus.oSramAddr, 0);
    check("reset rdata", bus.oRData, 0);
    Reset = 1'b1;
    @(negedge Clock);

    // WAIT_CYCLES = 1 and 15 builds run side by side.
    bus1.iReq0 = 1'b1; bus1.iWe0 = 1'b1; bus1.iAddr0 = 19'h00123; bus1.iWData0 = 8'h11;
    bus15.iReq1 = 1'b1; bus15.iWe1 = 1'b0; bus15.iAddr1 = 19'h55555; bus15.iSramData = 8'hC3;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clock);
      if (!bus1.oSramWe) we1++;
      if (!bus15.oSramOe) oe15++;
      if ((!bus1.oSramWe || !bus1.oSramOe) && (bus1.oSramCe || k == 1)) v1++;
      if ((!bus15.oSramWe || !bus15.oSramOe) && (bus15.oSramCe || k == 1)) v15++;
      if (bus1.oAck0 && k1 == 0) begin k1 = k; bus1.iReq0 = 1'b0; end
      if (bus15.oAck1 && k15 == 0) begin k15 = k; rd15 = bus15.oRData; bus15.iReq1 = 1'b0; end
    end
    check("w1 ack latency", k1, 3);
    check("w15 ack latency", k15, 17);
    check("w1 we low cycles", we1, 1);
    check("w15 oe low cycles", oe15, 15);
    check("w15 rdata", rd15, 8'hC3);
    check("w1 strobe order", v1, 0);
    check("w15 strobe order", v15, 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous requests; last grant was port 0.
    bus.iReq0 = 1'b1; bus.iWe0 = 1'b1; bus.iAddr0 = 19'h00AAA; bus.iWData0 = 8'h01;
    bus.iReq1 = 1'b1; bus.iWe1 = 1'b1; bus.iAddr1 = 19'h00BBB; bus.iWData1 = 8'h02;
    t_ack[0] = 0; t_ack[1] = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clock);
      if (bus.oAck0 && t_ack[0] == 0) begin t_ack[0] = k; bus.iReq0 = 1'b0; end
      if (bus.oAck1 && t_ack[1] == 0) begin t_ack[1] = k; bus.iReq1 = 1'b0; end
    end
    check("simul port0 ack time", t_ack[0], RR ? 9 : 4);
    check("simul port1 ack time", t_ack[1], RR ? 4 : 9);

    // Reset mid-write, then port 1 read.
    bus.iReq0 = 1'b1; bus.iWe0 = 1'b1; bus.iAddr0 = 19'h0F0F0; bus.iWData0 = 8'h5C;
    repeat (2) @(negedge Clock);
    check("pre-reset we low", bus.oSramWe, 1'b0);
    Reset = 1'b0;
    bus.iReq0 = 1'b0;
    repeat (5) @(negedge Clock);
    check("abort strobes", {bus.oSramCe, bus.oSramWe, bus.oSramOe}, 3'b111);
    check("abort acks", {bus.oAck0, bus.oAck1}, 2'b00);
    check("abort addr", bus.oSramAddr, 0);
    check("abort wdata", bus.oSramData, 0);
    check("abort rdata", bus.oRData, 0);
    Reset = 1'b1;
    abort_acks = 0;
    repeat (8) begin
      @(negedge Clock);
      if (bus.oAck0 || bus.oAck1) abort_acks++;
    end
    check("aborted not acked", abort_acks, 0);
    pv = '{port: 1'b1, we: 1'b0, addr: 19'h00ABC, wdata: 8'h00, sram: 8'h77, exp_rd: 8'h77};
    run_vec(pv, "post-reset");

    // Port 0 continuously requesting, port 1 also requesting.
    bus.iReq0 = 1'b1; bus.iWe0 = 1'b1; bus.iAddr0 = 19'h00100; bus.iWData0 = 8'h10;
    bus.iReq1 = 1'b1; bus.iWe1 = 1'b1; bus.iAddr1 = 19'h00200; bus.iWData1 = 8'h20;
    n_gr = 0; t_last = 0;
    for (int k = 1; k <= 40 && n_gr < 4; k++) begin
      @(negedge Clock);
      if (bus.oAck0 || bus.oAck1) begin
        order[n_gr] = bus.oAck1;
        n_gr++;
        t_last = k;
      end
    end
    bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
    check("stream grant count", n_gr, 4);
    check("stream 4th ack time", t_last, 4 + 3 * (W + 3));
    check("stream grant0", order[0], 1'b0);
    check("stream grant1", order[1], RR ? 1'b1 : 1'b0);
    check("stream grant2", order[2], 1'b0);
    check("stream grant3", order[3], RR ? 1'b1 : 1'b0);
    repeat (3) @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
